// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Multi-cycle multiply/divide unit that owns the architectural
//                HI/LO registers. MULT/MULTU run for MUL_CYCLES cycles and
//                DIV/DIVU for DIV_CYCLES cycles with Busy high. MTHI/MTLO
//                write in a single edge. While Busy is high, HI and LO hold
//                their previous values.
//                Optional feature: define MDU_DIV_EN to build the divider.
//                Without it, DIV/DIVU behave as no-ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] C_MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] C_DIV_LOAD = 4'(DIV_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, b_q;
    logic        sgn_q;

    // Request decode: only honoured while idle, so requests made while Busy is high are dropped.
    logic w_idle_req;
    logic w_start_mul;
    logic w_start_div;
    logic w_mthi;
    logic w_mtlo;
    logic w_sgn;
    logic w_done;

    assign w_idle_req  = Start && (state_q == S_IDLE);
    assign w_start_mul = w_idle_req && ((Op == 3'd1) || (Op == 3'd2));
`ifdef MDU_DIV_EN
    assign w_start_div = w_idle_req && ((Op == 3'd3) || (Op == 3'd4));
`else
    assign w_start_div = 1'b0;
`endif
    assign w_mthi = w_idle_req && (Op == 3'd5);
    assign w_mtlo = w_idle_req && (Op == 3'd6);
    assign w_sgn  = (Op == 3'd1) || (Op == 3'd3);
    // Final edge of an operation: the counter moves from 1 to 0.
    assign w_done = (state_q != S_IDLE) && (cnt_q == 4'd1);

    // Multiplier: sign- or zero-extend to 64 bits, so one multiply covers both.
    logic [63:0] w_mul_a, w_mul_b, w_prod;
    assign w_mul_a = {{32{sgn_q & a_q[31]}}, a_q};
    assign w_mul_b = {{32{sgn_q & b_q[31]}}, b_q};
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef MDU_DIV_EN
    // Divider on magnitudes. The quotient is negative when the operand signs
    // differ, and the remainder follows the dividend's sign.
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;
    assign w_a_mag = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign w_b_mag = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_quo   = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = (sgn_q && a_q[31]) ? (32'd0 - w_r_mag) : w_r_mag;
`endif

    // State register: asynchronous reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load the latency counter on accept, and count down to completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_mul) begin
                    state_d = S_MUL;
                    cnt_d   = C_MUL_LOAD;
                end else if (w_start_div) begin
                    state_d = S_DIV;
                    cnt_d   = C_DIV_LOAD;
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: Busy follows the next state, and HI/LO change only on a move or a completion.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (w_mthi) begin
            hi_d = A;
        end
        if (w_mtlo) begin
            lo_d = A;
        end
        if (w_done && (state_q == S_MUL)) begin
            hi_d = w_prod[63:32];
            lo_d = w_prod[31:0];
        end
`ifdef MDU_DIV_EN
        // A divide by zero still takes the full latency but leaves HI/LO untouched.
        if (w_done && (state_q == S_DIV) && (b_q != 32'd0)) begin
            hi_d = w_rem;
            lo_d = w_quo;
        end
`endif
    end

    // Datapath registers: HI/LO/Busy, and the operands captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            sgn_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            if (w_start_mul || w_start_div) begin
                a_q   <= A;
                b_q   <= B;
                sgn_q <= w_sgn;
            end
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle multiply/divide unit holding the architectural HI and LO registers for the MIPS datapath.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode/execute stage and asserts Busy while an operation is in flight.
- Drives HI and LO to the downstream 32-bit 2:1 select, which picks the MFHI/MFLO result for writeback.

## Interface
Parameters:
- MUL_CYCLES, 5, cycles Busy stays high for MULT/MULTU; legal range 1..15
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU; legal range 1..15

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- B  input  32  operand rt (divisor / multiplier)
- Op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- Start  input  1  request strobe, sampled on rising clk
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, MUL, DIV. A 4-bit down-counter tracks the remaining cycles.
- **IDLE, Start=1:**
  - Op 1/2: capture A and B, load the counter with MUL_CYCLES, go to MUL.
  - Op 3/4: capture A and B, load the counter with DIV_CYCLES, go to DIV.
  - Op 5: HI <= A at the same edge; stay in IDLE.
  - Op 6: LO <= A at the same edge; stay in IDLE.
  - Op 0/7: no effect.
- **MUL/DIV:** the counter decrements every edge. On the edge where it reaches 0, commit HI/LO and return to IDLE.
- **Start while Busy=1:** ignored completely, including MTHI/MTLO. Changes on A/B during Busy have no effect (operands are captured).
- **HI/LO during Busy:** hold their previous values. No partial results are ever visible.
- **MULT:** signed 32x32 -> 64. HI = product[63:32], LO = product[31:0].
- **MULTU:** same split, unsigned operands.
- **DIVU:** LO = unsigned quotient, HI = unsigned remainder.
- **DIV:** quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- **Divide by zero (DIV or DIVU):** still runs the full DIV_CYCLES with Busy high. HI and LO are left unchanged at completion.
- **Reset (any time, including mid-operation):** HI=0, LO=0, Busy=0, state IDLE, counter 0. The in-flight result is discarded.
- The internal implementation style (combinational product, or iterative shift-add / restoring division) is free, provided the latency and results above hold exactly.

## Timing
- **Busy:** registered, reset value 0. It rises at the edge that accepts a MULT/MULTU/DIV/DIVU.
- **Busy duration:** exactly MUL_CYCLES (or DIV_CYCLES) clock cycles.
- **Completion edge:** Busy falls and HI/LO update at the same edge.
- **Back-to-back:** a new Start is accepted in the first cycle Busy reads 0, so there is zero dead cycles between operations.
- **MTHI/MTLO:** 1-edge latency, Busy is never asserted.
- **Outputs:** HI and LO are register outputs, with no combinational path from any input.
- **Reset:** asynchronous assertion, synchronous release as seen at the next clk edge.

## Configuration
- Macro: MDU_DIV_EN.
- **Defined:** DIV/DIVU are implemented as described above.
- **Undefined:**
  - The divider logic is omitted entirely.
  - Op 3/4 behave as Op 0: no Busy, HI/LO unchanged.
  - MULT/MULTU/MTHI/MTLO are unaffected.
  - DIV_CYCLES is unused.

## Test plan
- **Reset mid-operation:** start MULT, pulse rst_n low on cycle 2 -> Busy=0, HI=0, LO=0 immediately. Next MULT runs normally.
- **MULT latency:** A=0xFFFFFFFD (-3), B=5, Start -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU with the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- **Divide:** DIVU A=100, B=7 -> after 10 cycles LO=0x0000000E, HI=0x00000002. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero:** preload HI=0x11111111 / LO=0x22222222 via MTHI/MTLO, then DIV A=5, B=0 -> Busy high 10 cycles, HI/LO unchanged.
- **Start during Busy:** MULT 2*3; on cycle 2 apply MTLO A=0xDEAD and change A/B -> ignored. Final HI=0, LO=6. A MULT issued the cycle Busy drops is accepted.
- **MDU_DIV_EN undefined:** DIVU 100/7 -> Busy stays 0, HI/LO unchanged. MULT still gives correct results.
